// File: rtl/pll_rst_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pll_rst_pkg
//  Description : Shared types and helpers for the PLL lock / reset sequencer.
//                Holds the sequencer state encoding and the counter-width
//                helper used to size the shared cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package pll_rst_pkg;

    // Sequencer states. Encodings are exported on SEQ_STATE for debug, so
    // they are fixed; the remaining 3-bit codes are unused and recover.
    typedef enum logic [2:0] {
        WAIT_LOCK  = 3'd0,
        FABRIC_REL = 3'd1,
        RUN        = 3'd2,
        CPU_RST    = 3'd3
    } seq_state_t;

    // Width of the shared counter: enough for the largest of the three
    // cycle counts, plus one bit of headroom so saturation never aliases
    // onto a terminal value.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage : pll_rst_pkg
`default_nettype wire

// File: rtl/sync_ff_chain.sv
`default_nettype none
// ============================================================================
//  Module      : sync_ff_chain
//  Description : Multi-stage flip-flop synchroniser for a single-bit
//                asynchronous input. Output latency is SYNC_STAGES cycles.
//  Ports       : clk   - destination clock
//                rst_n - asynchronous active-low reset (chain clears to 0)
//                i_d   - asynchronous input
//                o_q   - synchronised output
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_ff_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule : sync_ff_chain
`default_nettype wire

// File: rtl/pll_lock_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pll_lock_reset_sequencer
//  Description : Qualifies the CCC PLL LOCK, then releases the fabric reset
//                followed by the CPU reset. Loss of lock re-asserts both
//                resets and sets a sticky LOCK_LOST flag; a software request
//                produces a fixed-width CPU-only reset pulse.
//  Ports       : CLK            - CCC GL0 clock
//                RESETN         - async active-low reset
//                LOCK           - PLL lock (async)
//                MSS_READY      - MSS fabric-interface ready (async)
//                CPU_RST_REQ    - single-cycle software CPU reset request
//                CLR_LOCK_LOST  - synchronous clear of LOCK_LOST
//                FABRIC_RESET_N - registered active-low fabric reset
//                CPU_RESET_N    - registered active-low CPU reset
//                LOCK_LOST      - sticky lock-loss flag
//                SEQ_STATE      - current state encoding (debug)
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_reset_sequencer
    import pll_rst_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int CPU_DELAY_CYCLES   = 16,
    parameter int SW_RESET_CYCLES    = 8,
    parameter int SYNC_STAGES        = 2
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       LOCK,
    input  logic       MSS_READY,
    input  logic       CPU_RST_REQ,
    input  logic       CLR_LOCK_LOST,
    output logic       FABRIC_RESET_N,
    output logic       CPU_RESET_N,
    output logic       LOCK_LOST,
    output logic [2:0] SEQ_STATE
);

    localparam int CNT_W = cnt_width(LOCK_STABLE_CYCLES, CPU_DELAY_CYCLES,
                                     SW_RESET_CYCLES);

    localparam logic [CNT_W-1:0] C_LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CPU_LAST  = CNT_W'(CPU_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_SW_LAST   = CNT_W'(SW_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic w_lock_s;
    logic w_ready_s;

    sync_ff_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_lock (
        .clk   (CLK),
        .rst_n (RESETN),
        .i_d   (LOCK),
        .o_q   (w_lock_s)
    );

    sync_ff_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_ready (
        .clk   (CLK),
        .rst_n (RESETN),
        .i_d   (MSS_READY),
        .o_q   (w_ready_s)
    );

    // ------------------------------------------------------------------
    // State / counter / output registers
    // ------------------------------------------------------------------
    seq_state_t       r_state;
    seq_state_t       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_lock_lost_set;
    logic             r_fabric_reset_n;
    logic             r_cpu_reset_n;
    logic             r_lock_lost;
    logic             w_fabric_next;
    logic             w_cpu_next;
    logic             w_lock_lost_next;

    // Saturating increment: the counter never wraps back onto a terminal
    // value and spuriously fires a transition.
    assign w_cnt_inc = (r_cnt == C_CNT_MAX) ? r_cnt : (r_cnt + C_CNT_ONE);

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state          <= WAIT_LOCK;
            r_cnt            <= '0;
            r_fabric_reset_n <= 1'b0;
            r_cpu_reset_n    <= 1'b0;
            r_lock_lost      <= 1'b0;
        end else begin
            r_state          <= w_state_next;
            r_cnt            <= w_cnt_next;
            r_fabric_reset_n <= w_fabric_next;
            r_cpu_reset_n    <= w_cpu_next;
            r_lock_lost      <= w_lock_lost_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_lock_lost_set = 1'b0;

        case (r_state)
            WAIT_LOCK: begin
                // Any low sample restarts the debounce count.
                if (w_lock_s) begin
                    if (r_cnt == C_LOCK_LAST) begin
                        w_state_next = FABRIC_REL;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end else begin
                    w_cnt_next = '0;
                end
            end
            FABRIC_REL: begin
                if (!w_lock_s) begin
                    w_state_next    = WAIT_LOCK;
                    w_lock_lost_set = 1'b1;
                end else if (w_ready_s) begin
                    if (r_cnt == C_CPU_LAST) begin
                        w_state_next = RUN;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end
            end
            RUN: begin
                // MSS_READY is deliberately not monitored here.
                if (!w_lock_s) begin
                    w_state_next    = WAIT_LOCK;
                    w_lock_lost_set = 1'b1;
                end else if (CPU_RST_REQ) begin
                    w_state_next = CPU_RST;
                end
            end
            CPU_RST: begin
                // Requests arriving here are dropped, so the pulse width is fixed.
                if (!w_lock_s) begin
                    w_state_next    = WAIT_LOCK;
                    w_lock_lost_set = 1'b1;
                end else if (r_cnt == C_SW_LAST) begin
                    w_state_next = RUN;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            default: begin
                w_state_next = WAIT_LOCK;
            end
        endcase

        // Every state starts counting from zero.
        if (w_state_next != r_state) begin
            w_cnt_next = '0;
        end
    end

    // ------------------------------------------------------------------
    // Output logic: decoded from the next state so the registered resets
    // change on the same edge as the state transition.
    // ------------------------------------------------------------------
    always_comb begin
        w_fabric_next = 1'b0;
        w_cpu_next    = 1'b0;
        case (w_state_next)
            FABRIC_REL: w_fabric_next = 1'b1;
            RUN: begin
                w_fabric_next = 1'b1;
                w_cpu_next    = 1'b1;
            end
            CPU_RST:    w_fabric_next = 1'b1;
            default: begin
                w_fabric_next = 1'b0;
                w_cpu_next    = 1'b0;
            end
        endcase

        // Set has priority over clear.
        if (w_lock_lost_set) begin
            w_lock_lost_next = 1'b1;
        end else if (CLR_LOCK_LOST) begin
            w_lock_lost_next = 1'b0;
        end else begin
            w_lock_lost_next = r_lock_lost;
        end
    end

    assign FABRIC_RESET_N = r_fabric_reset_n;
    assign CPU_RESET_N    = r_cpu_reset_n;
    assign LOCK_LOST      = r_lock_lost;
    assign SEQ_STATE      = r_state;

endmodule : pll_lock_reset_sequencer
`default_nettype wire

// File: tb/tb_pll_lock_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pll_lock_reset_sequencer
//  Description : Scoreboard bench. Stimulus pushes the expected output
//                changes {FABRIC_RESET_N, CPU_RESET_N, LOCK_LOST} with the
//                clock cycle they must appear on; a monitor pops and checks
//                each observed change.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_lock_reset_sequencer;

    logic       CLK;
    logic       RESETN;
    logic       LOCK;
    logic       MSS_READY;
    logic       CPU_RST_REQ;
    logic       CLR_LOCK_LOST;
    logic       FABRIC_RESET_N;
    logic       CPU_RESET_N;
    logic       LOCK_LOST;
    logic [2:0] SEQ_STATE;

    pll_lock_reset_sequencer #(
        .LOCK_STABLE_CYCLES (8),
        .CPU_DELAY_CYCLES   (4),
        .SW_RESET_CYCLES    (3),
        .SYNC_STAGES        (2)
    ) dut (
        .CLK            (CLK),
        .RESETN         (RESETN),
        .LOCK           (LOCK),
        .MSS_READY      (MSS_READY),
        .CPU_RST_REQ    (CPU_RST_REQ),
        .CLR_LOCK_LOST  (CLR_LOCK_LOST),
        .FABRIC_RESET_N (FABRIC_RESET_N),
        .CPU_RESET_N    (CPU_RESET_N),
        .LOCK_LOST      (LOCK_LOST),
        .SEQ_STATE      (SEQ_STATE)
    );

    typedef struct {
        int         cyc;
        logic [2:0] val;   // {fabric_n, cpu_n, lock_lost}
        string      name;
    } ev_t;

    ev_t        exp_q[$];
    int         cyc;
    int         n_tests;
    int         n_fail;
    logic [2:0] prev_val;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic push(input int c, input logic [2:0] v, input string n);
        ev_t e;
        e.cyc  = c;
        e.val  = v;
        e.name = n;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #3;
        end
    endtask

    task automatic check(input string n, input logic [2:0] act, input logic [2:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", n, act, exp);
        end
    endtask

    // Monitor: every change of the output tuple must match the next
    // scoreboard entry in both value and cycle.
    initial begin
        prev_val = 3'b000;
        forever begin
            logic [2:0] cur;
            @(negedge CLK);
            cur = {FABRIC_RESET_N, CPU_RESET_N, LOCK_LOST};
            if (cur !== prev_val) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change: got %b at cycle %0d, expected no change",
                             cur, cyc);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    if (cur !== e.val || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL %s: got %b at cycle %0d, expected %b at cycle %0d",
                                 e.name, cur, cyc, e.val, e.cyc);
                    end
                end
                prev_val = cur;
            end
        end
    end

    initial begin
        int b;
        n_tests       = 0;
        n_fail        = 0;
        RESETN        = 1'b1;
        LOCK          = 1'b0;
        MSS_READY     = 1'b0;
        CPU_RST_REQ   = 1'b0;
        CLR_LOCK_LOST = 1'b0;
        #1 RESETN = 1'b0;

        // Reset state
        step(5);
        check("reset_outputs", {FABRIC_RESET_N, CPU_RESET_N, LOCK_LOST}, 3'b000);
        check("reset_state", SEQ_STATE, 3'd0);

        // Power-up bring-up
        RESETN    = 1'b1;
        LOCK      = 1'b1;
        MSS_READY = 1'b1;
        b = cyc;
        push(b + 10, 3'b100, "pwr_fabric_rel");
        push(b + 14, 3'b110, "pwr_cpu_rel");
        step(16);
        check("run_state", SEQ_STATE, 3'd2);

        // Software CPU reset, second request inside the window ignored
        b = cyc;
        CPU_RST_REQ = 1'b1;
        push(b + 1, 3'b100, "sw_rst_low");
        push(b + 4, 3'b110, "sw_rst_high");
        step(1);
        CPU_RST_REQ = 1'b0;
        step(1);
        CPU_RST_REQ = 1'b1;
        step(1);
        CPU_RST_REQ = 1'b0;
        step(4);

        // Lock loss in RUN, then re-qualification keeps LOCK_LOST
        b = cyc;
        LOCK = 1'b0;
        push(b + 3, 3'b001, "lock_loss");
        step(5);
        b = cyc;
        LOCK = 1'b1;
        push(b + 10, 3'b101, "requal_fabric");
        push(b + 14, 3'b111, "requal_cpu");
        step(16);

        // Clear sticky flag, then MSS_READY falling in RUN does nothing
        b = cyc;
        CLR_LOCK_LOST = 1'b1;
        push(b + 1, 3'b110, "clr_lock_lost");
        step(1);
        CLR_LOCK_LOST = 1'b0;
        MSS_READY = 1'b0;
        step(6);

        // Lock loss and clear in the same cycle: set wins
        b = cyc;
        LOCK = 1'b0;
        push(b + 3, 3'b001, "set_beats_clear");
        step(2);
        CLR_LOCK_LOST = 1'b1;
        step(1);
        CLR_LOCK_LOST = 1'b0;
        step(3);

        // Lock glitch restarts debounce; MSS_READY held low after release
        b = cyc;
        LOCK = 1'b1;
        step(5);
        LOCK = 1'b0;
        step(1);
        LOCK = 1'b1;
        push(b + 16, 3'b101, "glitch_fabric_rel");
        step(30);
        b = cyc;
        MSS_READY = 1'b1;
        push(b + 6, 3'b111, "ready_cpu_rel");
        step(8);

        // Async reset in the middle of a software CPU reset
        b = cyc;
        CPU_RST_REQ = 1'b1;
        push(b + 1, 3'b101, "sw2_rst_low");
        step(1);
        CPU_RST_REQ = 1'b0;
        step(1);
        push(b + 2, 3'b000, "async_reset");
        RESETN = 1'b0;
        #1;
        check("async_outputs", {FABRIC_RESET_N, CPU_RESET_N, LOCK_LOST}, 3'b000);
        check("async_state", SEQ_STATE, 3'd0);
        step(3);
        RESETN = 1'b1;
        b = cyc;
        push(b + 10, 3'b100, "restart_fabric_rel");
        push(b + 14, 3'b110, "restart_cpu_rel");
        step(18);

        // Every expected change must have been observed
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending events, expected 0 (next %s)",
                     exp_q.size(), exp_q[0].name);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pll_lock_reset_sequencer
`default_nettype wire
